load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I load/store sequencer driving a single-beat memory bus with
//            byte lanes, sign/zero extension, and an ack timeout.
//            Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned
//            halfword/word accesses instead of truncating the low address bits.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state_q, w_state_d;
    logic [7:0]  r_cnt_q, w_cnt_d;
    logic        r_we_q, w_we_d;
    logic [31:0] r_addr_q, w_addr_d;
    logic [31:0] r_wdata_q, w_wdata_d;
    logic [3:0]  r_be_q, w_be_d;
    logic [31:0] r_rdata_q, w_rdata_d;
    logic        r_fault_q, w_fault_d;
    logic        r_is_load_q, w_is_load_d;
    logic [2:0]  r_funct3_q, w_funct3_d;
    logic [1:0]  r_off_q, w_off_d;

    logic        w_f3_ok, w_misalign, w_legal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_shift, w_load;
    logic [15:0] w_half;

    always_comb begin
        w_f3_ok    = is_load ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                             : (funct3 <= 3'b010);
        w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
        w_legal    = w_f3_ok && !w_misalign;
`else
        w_legal    = w_f3_ok;
`endif
        case (funct3[1:0])
            2'b00:   begin w_be = 4'b0001 << addr[1:0];             w_wdata = {4{wdata[7:0]}};  end
            2'b01:   begin w_be = addr[1] ? 4'b1100 : 4'b0011;      w_wdata = {2{wdata[15:0]}}; end
            default: begin w_be = 4'b1111;                          w_wdata = wdata;            end
        endcase
    end

    // Lane extraction uses the byte offset captured when the access was accepted.
    always_comb begin
        w_shift = mem_rdata >> {r_off_q, 3'b000};
        w_half  = r_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3_q)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_we_d      = r_we_q;
        w_addr_d    = r_addr_q;
        w_wdata_d   = r_wdata_q;
        w_be_d      = r_be_q;
        w_rdata_d   = r_rdata_q;
        w_fault_d   = r_fault_q;
        w_is_load_d = r_is_load_q;
        w_funct3_d  = r_funct3_q;
        w_off_d     = r_off_q;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_fault_d   = !w_legal;
                    w_is_load_d = is_load;
                    w_funct3_d  = funct3;
                    w_off_d     = addr[1:0];
                    if (w_legal) begin
                        w_state_d = S_REQ;
                        w_cnt_d   = 8'd0;
                        w_we_d    = !is_load;
                        w_addr_d  = {addr[31:2], 2'b00};
                        w_be_d    = w_be;
                        w_wdata_d = w_wdata;
                    end else begin
                        w_state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    w_state_d = S_DONE;
                    if (r_is_load_q) w_rdata_d = w_load;
                end else if (r_cnt_q >= C_TO_LAST) begin
                    w_state_d = S_DONE;
                    w_fault_d = 1'b1;
                    w_rdata_d = 32'd0;
                end else if (r_cnt_q != 8'hFF) begin
                    w_cnt_d = r_cnt_q + 8'd1;
                end
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_cnt_q     <= 8'd0;
            r_we_q      <= 1'b0;
            r_addr_q    <= 32'd0;
            r_wdata_q   <= 32'd0;
            r_be_q      <= 4'd0;
            r_rdata_q   <= 32'd0;
            r_fault_q   <= 1'b0;
            r_is_load_q <= 1'b0;
            r_funct3_q  <= 3'd0;
            r_off_q     <= 2'd0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_we_q      <= w_we_d;
            r_addr_q    <= w_addr_d;
            r_wdata_q   <= w_wdata_d;
            r_be_q      <= w_be_d;
            r_rdata_q   <= w_rdata_d;
            r_fault_q   <= w_fault_d;
            r_is_load_q <= w_is_load_d;
            r_funct3_q  <= w_funct3_d;
            r_off_q     <= w_off_d;
        end
    end

    // Bus qualifiers come straight from the state so a reset drops them at once.
    assign busy      = (r_state_q != S_IDLE);
    assign done      = (r_state_q == S_DONE);
    assign mem_req   = (r_state_q == S_REQ);
    assign mem_we    = r_we_q && (r_state_q == S_REQ);
    assign mem_addr  = r_addr_q;
    assign mem_wdata = r_wdata_q;
    assign mem_be    = r_be_q;
    assign rdata     = r_rdata_q;
    assign fault     = r_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed-vector bench for load_store_unit with a done-side
//            scoreboard; expectations follow LSU_MISALIGN_TRAP_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int unsigned C_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst, start, is_load, mem_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, mem_rdata;
    logic        busy, done, fault, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    load_store_unit #(.TIMEOUT(C_TIMEOUT)) u_dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .fault(fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        logic        chk_rd;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_fault", {31'd0, fault}, {31'd0, e.fault});
                chk("done_cycle", cyc, e.cyc);
                if (e.chk_rd) chk("done_rdata", rdata, e.rdata);
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({name, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    // d >= 0: ack after d wait cycles; d < 0: never ack (timeout).
    task automatic issue(input string name, input logic ld, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic legal,
                         input int d, input logic [31:0] rd, input logic exp_fault,
                         input logic [31:0] exp_rd, input logic chk_rd,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd);
        exp_t e;
        int   k, n;
        @(negedge clk);
        start = 1'b1; is_load = ld; funct3 = f3; addr = a; wdata = wd;
        k = cyc + 1;
        e.fault = exp_fault; e.rdata = exp_rd; e.chk_rd = chk_rd;
        e.cyc = !legal ? k : (d < 0 ? k + int'(C_TIMEOUT) : k + 1 + d);
        exp_q.push_back(e);
        @(negedge clk);
        // A garbage request held on start while busy must be ignored.
        start = 1'b1; is_load = 1'b0; funct3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        if (!legal) begin
            chk({name, "_no_req"}, {31'd0, mem_req}, 32'd0);
        end else begin
            chk({name, "_req"}, {31'd0, mem_req}, 32'd1);
            chk({name, "_we"}, {31'd0, mem_we}, {31'd0, !ld});
            chk({name, "_addr"}, mem_addr, exp_addr);
            chk({name, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
            if (!ld) chk({name, "_wdata"}, mem_wdata, exp_wd);
            if (d < 0) begin
                n = 0;
                while (mem_req && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk({name, "_req_cycles"}, n, C_TIMEOUT);
            end else begin
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    chk({name, "_hold_req"}, {31'd0, mem_req}, 32'd1);
                    chk({name, "_hold_be"}, {28'd0, mem_be}, {28'd0, exp_be});
                    chk({name, "_hold_wdata"}, mem_wdata, exp_wd);
                end
                mem_ack = 1'b1; mem_rdata = rd;
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = 32'h0;
                chk({name, "_req_drop"}, {31'd0, mem_req}, 32'd0);
            end
        end
        start = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; is_load = 1'b0; funct3 = 3'd0; addr = 32'd0;
        wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        issue("sw",  1'b0, 3'b010, 32'h104, 32'hDEADBEEF, 1'b1, 0, 32'h0,
              1'b0, 32'h0, 1'b0, 32'h104, 4'b1111, 32'hDEADBEEF);
        issue("lb",  1'b1, 3'b000, 32'h203, 32'h0, 1'b1, 0, 32'h80FFFF7F,
              1'b0, 32'hFFFFFF80, 1'b1, 32'h200, 4'b1000, 32'h0);
        issue("lbu", 1'b1, 3'b100, 32'h203, 32'h0, 1'b1, 1, 32'h80FFFF7F,
              1'b0, 32'h00000080, 1'b1, 32'h200, 4'b1000, 32'h0);
        issue("sh",  1'b0, 3'b001, 32'h12, 32'h0000ABCD, 1'b1, 3, 32'h0,
              1'b0, 32'h0, 1'b0, 32'h10, 4'b1100, 32'hABCDABCD);
        issue("lh",  1'b1, 3'b001, 32'h202, 32'h0, 1'b1, 0, 32'h80FFFF7F,
              1'b0, 32'hFFFF80FF, 1'b1, 32'h200, 4'b1100, 32'h0);
        issue("lhu", 1'b1, 3'b101, 32'h200, 32'h0, 1'b1, 0, 32'h80FFFF7F,
              1'b0, 32'h0000FF7F, 1'b1, 32'h200, 4'b0011, 32'h0);
        issue("sb",  1'b0, 3'b000, 32'h101, 32'h123456A5, 1'b1, 0, 32'h0,
              1'b0, 32'h0, 1'b0, 32'h100, 4'b0010, 32'hA5A5A5A5);
        issue("lw_to", 1'b1, 3'b010, 32'h400, 32'h0, 1'b1, -1, 32'h0,
              1'b1, 32'h0, 1'b1, 32'h400, 4'b1111, 32'h0);
        issue("ld_bad", 1'b1, 3'b011, 32'h500, 32'h0, 1'b0, 0, 32'h0,
              1'b1, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0);
        issue("st_bad", 1'b0, 3'b100, 32'h500, 32'h0, 1'b0, 0, 32'h0,
              1'b1, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        issue("lw_mis", 1'b1, 3'b010, 32'h102, 32'h0, 1'b0, 0, 32'h0,
              1'b1, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0);
`else
        issue("lw_mis", 1'b1, 3'b010, 32'h102, 32'h0, 1'b1, 0, 32'h13572468,
              1'b0, 32'h13572468, 1'b1, 32'h100, 4'b1111, 32'h0);
`endif

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h600;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);
        chk("rst_prio_req", {31'd0, mem_req}, 32'd0);

        // Reset abandons an access in flight; then a start alongside a stray ack.
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h300;
        @(negedge clk);
        start = 1'b0;
        chk("abandon_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abandon_req_drop", {31'd0, mem_req}, 32'd0);
        chk("abandon_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        begin
            exp_t e;
            start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h304;
            mem_ack = 1'b1; mem_rdata = 32'h11111111;
            e.fault = 1'b0; e.rdata = 32'h5A5A0001; e.chk_rd = 1'b1; e.cyc = cyc + 2;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b0;
        chk("second_req", {31'd0, mem_req}, 32'd1);
        chk("second_addr", mem_addr, 32'h304);
        mem_ack = 1'b1; mem_rdata = 32'h5A5A0001;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        wait_idle("second");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
